// File: rtl/stage_mem_lsu.sv
// Memory-access pipeline stage: issues loads/stores over a req/gnt/rvalid handshake,
// stalls upstream while an access is outstanding, and extends load data.
module stage_mem_lsu #(
  parameter int unsigned WD_SIZE        = 32,
  parameter int unsigned INSTR_REG_SIZE = 5,
  parameter int unsigned PC_SIZE        = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      valid_i,
  input  logic [PC_SIZE-1:0]        pc_br_i,
  input  logic [INSTR_REG_SIZE-1:0] rd_i,
  input  logic [WD_SIZE-1:0]        alu_result_i,
  input  logic                      alu_zero_i,
  input  logic [WD_SIZE-1:0]        rs2_data_i,
  input  logic                      ctrl_ld_i,
  input  logic                      ctrl_st_i,
  input  logic                      ctrl_br_i,
  input  logic                      ctrl_reg_write_i,
  input  logic [2:0]                ctrl_mem_width_i,
  output logic                      stall_o,
  output logic [INSTR_REG_SIZE-1:0] rd_dc_o,
  output logic                      valid_o,
  output logic                      take_br_o,
  output logic                      ctrl_ld_o,
  output logic                      ctrl_reg_write_o,
  output logic                      misaligned_o,
  output logic [PC_SIZE-1:0]        pc_br_o,
  output logic [INSTR_REG_SIZE-1:0] rd_o,
  output logic [WD_SIZE-1:0]        alu_result_o,
  output logic [WD_SIZE-1:0]        mem_data_o,
  output logic                      dmem_req_o,
  output logic                      dmem_we_o,
  output logic [WD_SIZE/8-1:0]      dmem_be_o,
  output logic [WD_SIZE-1:0]        dmem_addr_o,
  output logic [WD_SIZE-1:0]        dmem_wr_data_o,
  input  logic                      dmem_gnt_i,
  input  logic                      dmem_rvalid_i,
  input  logic [WD_SIZE-1:0]        dmem_rd_data_i
);

  localparam int unsigned NB = WD_SIZE / 8;
  localparam int unsigned OW = $clog2(NB);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;
  state_e state_q, state_d;

  logic [OW-1:0]      offset;
  logic [OW-1:0]      align_mask;
  logic [3:0]         nbytes;
  logic               illegal, mem_op, misaligned, aligned_op;
  logic [WD_SIZE-1:0] ld_lane, ld_ext;

  assign offset  = alu_result_i[OW-1:0];
  assign nbytes  = 4'd1 << ctrl_mem_width_i[1:0];
  assign rd_dc_o = rd_i;

  always_comb begin
    align_mask = '0;
    case (ctrl_mem_width_i[1:0])
      2'd0:    align_mask = '0;
      2'd1:    align_mask = OW'(1);
      2'd2:    align_mask = OW'(3);
      default: align_mask = OW'(7);
    endcase
  end

  // D and WU only exist on the 64-bit datapath; funct3 111 is never legal.
  assign illegal    = (ctrl_mem_width_i == 3'b111) ||
                      ((WD_SIZE == 32) &&
                       ((ctrl_mem_width_i == 3'b011) || (ctrl_mem_width_i == 3'b110)));
  assign mem_op     = valid_i & (ctrl_ld_i | ctrl_st_i);
  assign misaligned = mem_op & (illegal | ((offset & align_mask) != '0));
  assign aligned_op = mem_op & ~misaligned;

  assign dmem_we_o   = ctrl_st_i;
  assign dmem_addr_o = alu_result_i & ~WD_SIZE'(NB - 1);

  always_comb begin
    dmem_be_o      = '0;
    dmem_wr_data_o = '0;
    for (int i = 0; i < NB; i++) begin
      dmem_be_o[i] = (i >= int'(offset)) && (i < int'(offset) + int'(nbytes));
      dmem_wr_data_o[8*i +: 8] = rs2_data_i[8*(i & (int'(nbytes) - 1)) +: 8];
    end
  end

  assign ld_lane = dmem_rd_data_i >> {offset, 3'b000};

  always_comb begin
    ld_ext = ld_lane;
    case (ctrl_mem_width_i)
      3'b000:  ld_ext = WD_SIZE'($signed(ld_lane[7:0]));
      3'b001:  ld_ext = WD_SIZE'($signed(ld_lane[15:0]));
      3'b010:  ld_ext = WD_SIZE'($signed(ld_lane[31:0]));
      3'b100:  ld_ext = WD_SIZE'(ld_lane[7:0]);
      3'b101:  ld_ext = WD_SIZE'(ld_lane[15:0]);
      3'b110:  ld_ext = WD_SIZE'(ld_lane[31:0]);
      default: ld_ext = ld_lane;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    dmem_req_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (aligned_op) begin
          dmem_req_o = 1'b1;
          state_d    = dmem_gnt_i ? StWait : StReq;
        end
      end
      StReq: begin
        dmem_req_o = aligned_op;
        if (dmem_gnt_i) state_d = StWait;
      end
      StWait: begin
        if (dmem_rvalid_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign stall_o = aligned_op & ~((state_q == StWait) & dmem_rvalid_i);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= StIdle;
      valid_o          <= 1'b0;
      take_br_o        <= 1'b0;
      ctrl_ld_o        <= 1'b0;
      ctrl_reg_write_o <= 1'b0;
      misaligned_o     <= 1'b0;
      pc_br_o          <= '0;
      rd_o             <= '0;
      alu_result_o     <= '0;
      mem_data_o       <= '0;
    end else begin
      state_q <= state_d;
      if (stall_o) begin
        // Bubble: control bits cleared, data fields hold.
        valid_o          <= 1'b0;
        take_br_o        <= 1'b0;
        ctrl_ld_o        <= 1'b0;
        ctrl_reg_write_o <= 1'b0;
        misaligned_o     <= 1'b0;
      end else begin
        valid_o          <= valid_i;
        take_br_o        <= valid_i & ctrl_br_i & alu_zero_i;
        ctrl_ld_o        <= ctrl_ld_i;
        ctrl_reg_write_o <= ctrl_reg_write_i & ~misaligned;
        misaligned_o     <= misaligned;
        pc_br_o          <= pc_br_i;
        rd_o             <= rd_i;
        alu_result_o     <= alu_result_i;
        mem_data_o       <= (aligned_op & ctrl_ld_i) ? ld_ext : '0;
      end
    end
  end

endmodule

// File: tb/tb_stage_mem_lsu.sv
// Bench for stage_mem_lsu: 32- and 64-bit instances driven from shared stimulus,
// directed cases plus randomized ops against a byte-level reference model.
module tb_stage_mem_lsu;

  logic        clk, rst_n, sel64;
  logic        valid, ld, st, br, zero, rw, gnt, rvalid;
  logic [2:0]  f3;
  logic [31:0] pc;
  logic [4:0]  rd;
  logic [63:0] alu, rs2, rdata;

  logic        s32_stall, s32_valid, s32_tbr, s32_ld, s32_rw, s32_mis, s32_req, s32_we;
  logic [4:0]  s32_rddc, s32_rd;
  logic [31:0] s32_pc, s32_alu, s32_mem, s32_addr, s32_wd;
  logic [3:0]  s32_be;
  logic        s64_stall, s64_valid, s64_tbr, s64_ld, s64_rw, s64_mis, s64_req, s64_we;
  logic [4:0]  s64_rddc, s64_rd;
  logic [31:0] s64_pc;
  logic [63:0] s64_alu, s64_mem, s64_addr, s64_wd;
  logic [7:0]  s64_be;

  stage_mem_lsu #(.WD_SIZE(32)) u32 (
    .clk(clk), .reset_n(rst_n), .valid_i(valid & ~sel64), .pc_br_i(pc), .rd_i(rd),
    .alu_result_i(alu[31:0]), .alu_zero_i(zero), .rs2_data_i(rs2[31:0]),
    .ctrl_ld_i(ld), .ctrl_st_i(st), .ctrl_br_i(br), .ctrl_reg_write_i(rw),
    .ctrl_mem_width_i(f3), .stall_o(s32_stall), .rd_dc_o(s32_rddc), .valid_o(s32_valid),
    .take_br_o(s32_tbr), .ctrl_ld_o(s32_ld), .ctrl_reg_write_o(s32_rw),
    .misaligned_o(s32_mis), .pc_br_o(s32_pc), .rd_o(s32_rd), .alu_result_o(s32_alu),
    .mem_data_o(s32_mem), .dmem_req_o(s32_req), .dmem_we_o(s32_we), .dmem_be_o(s32_be),
    .dmem_addr_o(s32_addr), .dmem_wr_data_o(s32_wd), .dmem_gnt_i(gnt & ~sel64),
    .dmem_rvalid_i(rvalid & ~sel64), .dmem_rd_data_i(rdata[31:0])
  );

  stage_mem_lsu #(.WD_SIZE(64)) u64 (
    .clk(clk), .reset_n(rst_n), .valid_i(valid & sel64), .pc_br_i(pc), .rd_i(rd),
    .alu_result_i(alu), .alu_zero_i(zero), .rs2_data_i(rs2),
    .ctrl_ld_i(ld), .ctrl_st_i(st), .ctrl_br_i(br), .ctrl_reg_write_i(rw),
    .ctrl_mem_width_i(f3), .stall_o(s64_stall), .rd_dc_o(s64_rddc), .valid_o(s64_valid),
    .take_br_o(s64_tbr), .ctrl_ld_o(s64_ld), .ctrl_reg_write_o(s64_rw),
    .misaligned_o(s64_mis), .pc_br_o(s64_pc), .rd_o(s64_rd), .alu_result_o(s64_alu),
    .mem_data_o(s64_mem), .dmem_req_o(s64_req), .dmem_we_o(s64_we), .dmem_be_o(s64_be),
    .dmem_addr_o(s64_addr), .dmem_wr_data_o(s64_wd), .dmem_gnt_i(gnt & sel64),
    .dmem_rvalid_i(rvalid & sel64), .dmem_rd_data_i(rdata)
  );

  // Selected-instance view
  logic        o_stall, o_valid, o_tbr, o_ld, o_rw, o_mis, o_req, o_we;
  logic [4:0]  o_rddc, o_rd;
  logic [31:0] o_pc;
  logic [63:0] o_alu, o_mem, o_addr, o_wd;
  logic [7:0]  o_be;
  assign o_stall = sel64 ? s64_stall : s32_stall;
  assign o_valid = sel64 ? s64_valid : s32_valid;
  assign o_tbr   = sel64 ? s64_tbr   : s32_tbr;
  assign o_ld    = sel64 ? s64_ld    : s32_ld;
  assign o_rw    = sel64 ? s64_rw    : s32_rw;
  assign o_mis   = sel64 ? s64_mis   : s32_mis;
  assign o_req   = sel64 ? s64_req   : s32_req;
  assign o_we    = sel64 ? s64_we    : s32_we;
  assign o_rddc  = sel64 ? s64_rddc  : s32_rddc;
  assign o_rd    = sel64 ? s64_rd    : s32_rd;
  assign o_pc    = sel64 ? s64_pc    : s32_pc;
  assign o_alu   = sel64 ? s64_alu   : {32'b0, s32_alu};
  assign o_mem   = sel64 ? s64_mem   : {32'b0, s32_mem};
  assign o_addr  = sel64 ? s64_addr  : {32'b0, s32_addr};
  assign o_wd    = sel64 ? s64_wd    : {32'b0, s32_wd};
  assign o_be    = sel64 ? s64_be    : {4'b0, s32_be};

  int n_cmp = 0;
  int n_fail = 0;

  // Observations from the most recent exec_op
  int          ob_stall_cnt, ob_vpulse;
  logic        ob_req0, ob_we, ob_unstable, ob_wait_req;
  logic [7:0]  ob_be;
  logic [63:0] ob_addr, ob_wd;
  logic        f_valid, f_tbr, f_ld, f_rw, f_mis;
  logic [63:0] f_alu, f_mem;
  logic [31:0] f_pc;
  logic [4:0]  f_rd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: byte-lane arithmetic straight from the access rules.
  task automatic ref_model(input int w, input logic [2:0] f, input logic [63:0] a_in,
                           input logic [63:0] s, input logic [63:0] r, output logic mis,
                           output logic [7:0] be, output logic [63:0] aa,
                           output logic [63:0] wd, output logic [63:0] lv);
    int nbw, nb, off, bits;
    logic [63:0] wm, a, lane, m;
    nbw = w / 8;
    nb  = 1 << f[1:0];
    wm  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    a   = a_in & wm;
    off = int'(a % 64'(nbw));
    mis = (f == 3'd7) || (w == 32 && (f == 3'd3 || f == 3'd6)) || (off % nb != 0);
    be  = 8'(((1 << nb) - 1) << off);
    aa  = a - 64'(off);
    wd  = '0;
    for (int i = 0; i < nbw; i++) wd[8*i +: 8] = s[8*(i % nb) +: 8];
    lane = r >> (8 * off);
    bits = 8 * nb;
    m    = (bits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
    lv   = lane & m;
    if (!f[2] && bits < w && lv[bits-1]) lv = lv | ~m;
    lv = lv & wm;
  endtask

  // Drives one instruction and answers the handshake: gnt after gd extra cycles,
  // rvalid rl cycles after gnt. Records what the stage did.
  task automatic exec_op(input logic s64, input logic i_ld, input logic i_st,
                         input logic i_br, input logic i_zero, input logic i_rw,
                         input logic [2:0] i_f3, input logic [63:0] i_alu,
                         input logic [63:0] i_rs2, input logic [63:0] i_rdata,
                         input logic [31:0] i_pc, input logic [4:0] i_rd,
                         input int gd, input int rl, input logic is_mem);
    @(negedge clk);
    sel64 = s64; valid = 1'b1; ld = i_ld; st = i_st; br = i_br; zero = i_zero; rw = i_rw;
    f3 = i_f3; alu = i_alu; rs2 = i_rs2; rdata = i_rdata; pc = i_pc; rd = i_rd;
    gnt = is_mem && (gd == 0); rvalid = 1'b0;
    #1;
    ob_req0 = o_req; ob_be = o_be; ob_addr = o_addr; ob_wd = o_wd; ob_we = o_we;
    ob_stall_cnt = int'(o_stall); ob_vpulse = 0; ob_unstable = 1'b0; ob_wait_req = 1'b0;
    if (is_mem) begin
      for (int c = 1; c <= gd; c++) begin
        @(negedge clk); gnt = (c == gd); #1;
        ob_stall_cnt += int'(o_stall); ob_vpulse += int'(o_valid);
        if (!o_req || o_be !== ob_be || o_addr !== ob_addr || o_wd !== ob_wd ||
            o_we !== ob_we) ob_unstable = 1'b1;
      end
      for (int c = 1; c <= rl; c++) begin
        @(negedge clk); gnt = 1'b0; rvalid = (c == rl); #1;
        ob_stall_cnt += int'(o_stall); ob_vpulse += int'(o_valid);
        if (o_req) ob_wait_req = 1'b1;
      end
    end
    @(negedge clk);
    valid = 1'b0; ld = 1'b0; st = 1'b0; br = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    #1;
    f_valid = o_valid; f_tbr = o_tbr; f_ld = o_ld; f_rw = o_rw; f_mis = o_mis;
    f_alu = o_alu; f_mem = o_mem; f_pc = o_pc; f_rd = o_rd;
  endtask

  task automatic test_reset;
    #12;
    for (int s = 0; s < 2; s++) begin
      sel64 = s[0]; #1;
      n_cmp++;
      if ({o_valid, o_tbr, o_ld, o_rw, o_mis, o_stall, o_req, o_pc, o_rd, o_alu, o_mem}
          !== '0) begin
        n_fail++;
        $display("FAIL reset_state w%0d: got valid=%b pc=%h alu=%h mem=%h req=%b, need 0",
                 s, o_valid, o_pc, o_alu, o_mem, o_req);
      end
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_lb32;
    exec_op(0, 1, 0, 0, 0, 1, 3'b000, 64'h1003, 0, 64'h80FF_FF7F, 0, 5'd3, 0, 1, 1);
    n_cmp++;
    if (ob_be !== 8'h08) begin
      n_fail++; $display("FAIL lb_be: got %b need 1000", ob_be);
    end
    n_cmp++;
    if (f_mem !== 64'hFFFF_FF80) begin
      n_fail++; $display("FAIL lb_data: got %h need ffffff80", f_mem);
    end
    exec_op(0, 1, 0, 0, 0, 1, 3'b100, 64'h1003, 0, 64'h80FF_FF7F, 0, 5'd3, 1, 1, 1);
    n_cmp++;
    if (f_mem !== 64'h0000_0080) begin
      n_fail++; $display("FAIL lbu_data: got %h need 00000080", f_mem);
    end
  endtask

  task automatic test_sh32;
    exec_op(0, 0, 1, 0, 0, 0, 3'b001, 64'h2002, 64'h1234_ABCD, 0, 0, 5'd17, 0, 1, 1);
    n_cmp++;
    if ({ob_req0, ob_we, ob_be} !== {1'b1, 1'b1, 8'h0C}) begin
      n_fail++; $display("FAIL sh_ctl: got req=%b we=%b be=%b need 1 1 1100",
                         ob_req0, ob_we, ob_be);
    end
    n_cmp++;
    if (ob_wd !== 64'hABCD_ABCD) begin
      n_fail++; $display("FAIL sh_wdata: got %h need abcdabcd", ob_wd);
    end
    n_cmp++;
    if (ob_addr !== 64'h2000) begin
      n_fail++; $display("FAIL sh_addr: got %h need 2000", ob_addr);
    end
    n_cmp++;
    if (o_rddc !== 5'd17) begin
      n_fail++; $display("FAIL rd_dc: got %0d need 17", o_rddc);
    end
  endtask

  task automatic test_delay;
    exec_op(0, 1, 0, 0, 0, 1, 3'b010, 64'h40, 0, 64'hCAFE_F00D, 32'h88, 5'd4, 3, 2, 1);
    n_cmp++;
    if (ob_stall_cnt != 5) begin
      n_fail++; $display("FAIL delay_stall: got %0d cycles need 5", ob_stall_cnt);
    end
    n_cmp++;
    if ({ob_unstable, ob_wait_req} !== 2'b00) begin
      n_fail++; $display("FAIL delay_req: got unstable=%b wait_req=%b need 0 0",
                         ob_unstable, ob_wait_req);
    end
    n_cmp++;
    if ({ob_vpulse != 0, f_valid} !== 2'b01) begin
      n_fail++; $display("FAIL delay_pulse: got early=%0d final=%b need 0 1",
                         ob_vpulse, f_valid);
    end
    n_cmp++;
    if (f_mem !== 64'hCAFE_F00D) begin
      n_fail++; $display("FAIL delay_data: got %h need cafef00d", f_mem);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_fail++; $display("FAIL delay_single: got valid_o=%b need 0", o_valid);
    end
  endtask

  task automatic test_misaligned;
    exec_op(0, 1, 0, 0, 0, 1, 3'b010, 64'h1002, 0, 64'h1111_2222, 0, 5'd6, 0, 1, 0);
    n_cmp++;
    if ({ob_req0, ob_stall_cnt != 0} !== 2'b00) begin
      n_fail++; $display("FAIL mis_issue: got req=%b stall=%0d need 0 0",
                         ob_req0, ob_stall_cnt);
    end
    n_cmp++;
    if ({f_valid, f_mis, f_rw} !== 3'b110) begin
      n_fail++; $display("FAIL mis_out: got valid=%b mis=%b rw=%b need 1 1 0",
                         f_valid, f_mis, f_rw);
    end
  endtask

  task automatic test_lw64;
    exec_op(1, 1, 0, 0, 0, 1, 3'b010, 64'h3004, 0, 64'h8000_0001_1234_5678, 0, 5'd1,
            1, 1, 1);
    n_cmp++;
    if (f_mem !== 64'hFFFF_FFFF_8000_0001) begin
      n_fail++; $display("FAIL lw64: got %h need ffffffff80000001", f_mem);
    end
    exec_op(1, 1, 0, 0, 0, 1, 3'b110, 64'h3004, 0, 64'h8000_0001_1234_5678, 0, 5'd1,
            0, 2, 1);
    n_cmp++;
    if (f_mem !== 64'h0000_0000_8000_0001) begin
      n_fail++; $display("FAIL lwu64: got %h need 0000000080000001", f_mem);
    end
    exec_op(1, 1, 0, 0, 0, 1, 3'b011, 64'h3000, 0, 64'h8765_4321_0FED_CBA9, 0, 5'd1,
            0, 1, 1);
    n_cmp++;
    if (f_mem !== 64'h8765_4321_0FED_CBA9) begin
      n_fail++; $display("FAIL ld64: got %h need 876543210fedcba9", f_mem);
    end
  endtask

  task automatic test_reset_mid;
    exec_op(0, 0, 0, 0, 0, 1, 3'b000, 64'hDEAD_BEEF, 0, 0, 32'h1234, 5'd9, 0, 1, 0);
    @(negedge clk);
    sel64 = 1'b0; valid = 1'b1; ld = 1'b1; f3 = 3'b010; alu = 64'h100; gnt = 1'b1;
    @(negedge clk); gnt = 1'b0; #1;
    n_cmp++;
    if ({o_req, o_alu} !== {1'b0, 64'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL mid_wait: got req=%b alu=%h need 0 deadbeef", o_req, o_alu);
    end
    #1 rst_n = 1'b0; #1;
    n_cmp++;
    if ({o_valid, o_pc, o_rd, o_alu, o_mem, o_mis} !== '0) begin
      n_fail++; $display("FAIL mid_rst_out: got valid=%b pc=%h alu=%h need 0",
                         o_valid, o_pc, o_alu);
    end
    n_cmp++;
    if (o_req !== 1'b1) begin
      n_fail++; $display("FAIL mid_rst_idle: got req=%b need 1", o_req);
    end
    valid = 1'b0; ld = 1'b0; #1;
    n_cmp++;
    if ({o_req, o_stall} !== 2'b00) begin
      n_fail++; $display("FAIL mid_rst_noreq: got req=%b stall=%b need 0 0", o_req, o_stall);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); rvalid = 1'b1; rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk); rvalid = 1'b0; #1;
    n_cmp++;
    if ({o_valid, o_mem} !== '0) begin
      n_fail++; $display("FAIL mid_late_rvalid: got valid=%b mem=%h need 0", o_valid, o_mem);
    end
  endtask

  task automatic test_random;
    logic        mis, is_mem, s, e_ld, e_st, e_br, e_zero, e_rw;
    logic [2:0]  f;
    logic [7:0]  e_be;
    logic [63:0] a, d, r, e_aa, e_wd, e_lv, wm, e_mem;
    logic [31:0] p;
    logic [4:0]  rdi;
    int          w, kind, gd, rl;
    for (int n = 0; n < 80; n++) begin
      s = 1'($urandom_range(0, 1));
      w = s ? 64 : 32;
      wm = s ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      kind = $urandom_range(0, 2);
      f = 3'($urandom_range(0, 7));
      a = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << f[1:0]) - 64'd1);
      d = {$urandom, $urandom}; r = {$urandom, $urandom};
      p = $urandom; rdi = 5'($urandom);
      e_ld = (kind == 1); e_st = (kind == 2);
      e_br = 1'($urandom); e_zero = 1'($urandom); e_rw = 1'($urandom);
      gd = $urandom_range(0, 3); rl = $urandom_range(1, 3);
      ref_model(w, f, a, d, r, mis, e_be, e_aa, e_wd, e_lv);
      mis = mis && (kind != 0);
      is_mem = (kind != 0) && !mis;
      e_mem = (e_ld && !mis) ? e_lv : 64'd0;
      exec_op(s, e_ld, e_st, e_br, e_zero, e_rw, f, a, d, r, p, rdi, gd, rl, is_mem);
      n_cmp++;
      if (ob_stall_cnt != (is_mem ? gd + rl : 0)) begin
        n_fail++; $display("FAIL rnd_stall #%0d: got %0d need %0d", n, ob_stall_cnt,
                           is_mem ? gd + rl : 0);
      end
      n_cmp++;
      if ({f_valid, f_tbr, f_ld, f_rw, f_mis} !==
          {1'b1, e_br & e_zero, e_ld, e_rw & ~mis, mis}) begin
        n_fail++; $display("FAIL rnd_ctl #%0d: got %b need %b", n,
                           {f_valid, f_tbr, f_ld, f_rw, f_mis},
                           {1'b1, e_br & e_zero, e_ld, e_rw & ~mis, mis});
      end
      n_cmp++;
      if (f_mem !== e_mem) begin
        n_fail++; $display("FAIL rnd_mem #%0d f3=%0d w%0d: got %h need %h", n, f, w,
                           f_mem, e_mem);
      end
      n_cmp++;
      if ({f_alu, f_pc, f_rd} !== {a & wm, p, rdi}) begin
        n_fail++; $display("FAIL rnd_fwd #%0d: got %h %h %h need %h %h %h", n, f_alu, f_pc,
                           f_rd, a & wm, p, rdi);
      end
      n_cmp++;
      if (ob_req0 !== is_mem) begin
        n_fail++; $display("FAIL rnd_req #%0d: got %b need %b", n, ob_req0, is_mem);
      end
      if (is_mem) begin
        n_cmp++;
        if ({ob_be, ob_addr, ob_we} !== {e_be, e_aa, e_st}) begin
          n_fail++; $display("FAIL rnd_bus #%0d: got be=%b addr=%h we=%b need %b %h %b", n,
                             ob_be, ob_addr, ob_we, e_be, e_aa, e_st);
        end
        n_cmp++;
        if ({ob_unstable, ob_wait_req, ob_vpulse != 0} !== 3'b000) begin
          n_fail++; $display("FAIL rnd_hs #%0d: got unstable=%b wait_req=%b early=%0d", n,
                             ob_unstable, ob_wait_req, ob_vpulse);
        end
        if (e_st) begin
          n_cmp++;
          if (ob_wd !== e_wd) begin
            n_fail++; $display("FAIL rnd_wdata #%0d: got %h need %h", n, ob_wd, e_wd);
          end
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; sel64 = 1'b0; valid = 1'b0; ld = 1'b0; st = 1'b0; br = 1'b0;
    zero = 1'b0; rw = 1'b0; gnt = 1'b0; rvalid = 1'b0; f3 = 3'b0; pc = '0; rd = '0;
    alu = '0; rs2 = '0; rdata = '0;
    test_reset;
    test_lb32;
    test_sh32;
    test_delay;
    test_misaligned;
    test_lw64;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
